// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) sequencer
// that owns the HI/LO registers.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state_reg, state_next;
  logic        op_reg, a_neg, b_neg, dz_reg, q_m1;
  logic [32:0] acc;     // Booth accumulator (sign-extended) or remainder
  logic [31:0] mq;      // multiplier or quotient
  logic [31:0] mcand;   // multiplicand or divisor magnitude
  logic [5:0]  count;

  logic        accept, is_dz;
  logic [31:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [32:0] booth_sum;
  logic [33:0] trial;

  assign accept = start && (state_reg == IDLE || state_reg == DONE);
  assign is_dz  = op && (b == 32'd0);
  assign a_mag  = a[31] ? -a : a;
  assign b_mag  = b[31] ? -b : b;

  // One extra accumulator bit keeps Booth exact when the multiplicand is -2^31.
  always_comb begin
    booth_sum = acc;
    case ({mq[0], q_m1})
      2'b01:   booth_sum = acc + {mcand[31], mcand};
      2'b10:   booth_sum = acc - {mcand[31], mcand};
      default: booth_sum = acc;
    endcase
  end

  assign trial   = {1'b0, acc[31:0], mq[31]} - {2'b00, mcand};
  assign quo_fix = (a_neg ^ b_neg) ? -mq : mq;
  assign rem_fix = a_neg ? -acc[31:0] : acc[31:0];

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (accept)                 state_next = is_dz ? DONE : RUN;
        else if (state_reg == DONE) state_next = IDLE;
        done     = (state_reg == DONE);
        div_zero = (state_reg == DONE) && dz_reg;
      end
      RUN: begin
        busy = 1'b1;
        if (count == 6'd1) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      dz_reg <= 1'b0;
      q_m1   <= 1'b0;
      acc    <= 33'd0;
      mq     <= 32'd0;
      mcand  <= 32'd0;
      count  <= 6'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            op_reg <= op;
            a_neg  <= a[31];
            b_neg  <= b[31];
            dz_reg <= is_dz;
            q_m1   <= 1'b0;
            acc    <= 33'd0;
            count  <= is_dz ? 6'd0 : 6'd32;
            mq     <= op ? a_mag : b;
            mcand  <= op ? b_mag : a;
          end
        end
        RUN: begin
          count <= count - 6'd1;
          if (op_reg) begin
            if (!trial[33]) acc <= trial[32:0];
            else            acc <= {acc[31:0], mq[31]};
            mq <= {mq[30:0], ~trial[33]};
          end else begin
            {acc, mq, q_m1} <= {booth_sum[32], booth_sum, mq};
          end
        end
        FIX: begin
          hi <= op_reg ? rem_fix : acc[31:0];
          lo <= op_reg ? quo_fix : mq;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/flag/timing,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    int          busy;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          busy_cnt = 0;
  int          stable_err = 0;
  logic        rst_seen = 1'b0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor
  always @(negedge clock) begin
    if (rst_seen) begin
      sb.delete();
      busy_cnt   = 0;
      model_hi   = 32'd0;
      model_lo   = 32'd0;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_dz", {31'd0, div_zero}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
    end else if (done) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s: hi=%h lo=%h dz=%0b cycle=%0d busy_cycles=%0d", e.name, hi, lo, div_zero, cyc, busy_cnt);
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_busy"}, busy_cnt, e.busy);
        chk({e.name, "_stable"}, stable_err, 32'd0);
        model_hi   = e.hi;
        model_lo   = e.lo;
        stable_err = 0;
      end
      busy_cnt = 0;
    end else begin
      if (div_zero) begin
        total++;
        $display("FAIL stray_div_zero: got 1, expected 0 (cycle %0d)", cyc);
      end
      if (hi !== model_hi || lo !== model_lo) stable_err++;
      if (busy) busy_cnt++;
    end
  end

  // Issue a request in the current cycle (cycle 0 = this cycle).
  task automatic drive(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input string name, output int p);
    exp_t e;
    p      = cyc;
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    e.hi   = ehi;
    e.lo   = elo;
    e.dz   = edz;
    e.cyc  = p + (edz ? 1 : 34);
    e.busy = edz ? 0 : 33;
    e.name = name;
    sb.push_back(e);
    @(negedge clock); #1;
    start = 1'b0;
    op    = $urandom_range(0, 1);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL timeout: got %0d pending results, expected 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic run(input logic o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                     input string name);
    int p;
    drive(o, x, y, ehi, elo, edz, name, p);
    wait_empty();
    @(negedge clock); #1;
  endtask

  initial begin
    int p;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #1;

    run(1'b0, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, "mult_3x5");
    run(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_7xm3");
    run(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, "mult_min_min");
    run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, "mult_m1_m1");
    run(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2");
    run(1'b1, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, "div_7_m2");
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, "div_min_m1");

    // Divide by zero keeps the previous HI/LO
    run(1'b0, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, "preload_3x5");
    run(1'b1, 32'd9, 32'd0, 32'h0, 32'd15, 1'b1, "div_9_0");

    // start pulses inside RUN must be ignored
    drive(1'b0, 32'd12, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFD0, 1'b0, "mult_ignored_start", p);
    while (cyc < p + 5) begin @(negedge clock); #1; end
    start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd0;
    @(negedge clock); #1 start = 1'b0;
    while (cyc < p + 20) begin @(negedge clock); #1; end
    start = 1'b1; op = 1'b0; a = 32'd99; b = 32'd99;
    @(negedge clock); #1 start = 1'b0;
    wait_empty();
    @(negedge clock); #1;

    // Back-to-back: new request sampled during the DONE cycle
    drive(1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, "mult_6x7", p);
    wait_empty();
    drive(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div_100_7_b2b", p);
    wait_empty();
    @(negedge clock); #1;

    // Reset in cycle 17 of a mult discards it
    drive(1'b0, 32'd1000, 32'd1000, 32'h0, 32'd1000000, 1'b0, "mult_reset_abort", p);
    while (cyc < p + 17) begin @(negedge clock); #1; end
    reset = 1'b1;
    @(negedge clock); #1 reset = 1'b0;
    repeat (40) begin @(negedge clock); #1; end
    run(1'b0, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, "mult_2x3_after_reset");

    repeat (3) @(negedge clock);
    #1 chk("final_stable", stable_err, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
